// File: rtl/mac_tcdm_req_slice_pkg.sv
// Shared types and defaults for the MAC engine TCDM request slice.
package mac_tcdm_req_slice_pkg;

  localparam int unsigned DEF_MP              = 4;
  localparam int unsigned DEF_ADDR_WIDTH      = 32;
  localparam int unsigned DEF_DATA_WIDTH      = 32;
  localparam int unsigned DEF_MAX_OUTSTANDING = 4;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0]   add;
    logic                        wen;
    logic [DEF_DATA_WIDTH/8-1:0] be;
    logic [DEF_DATA_WIDTH-1:0]   data;
  } tcdm_req_t;

  // Bit width of one packed {add, wen, be, data} request for arbitrary widths.
  function automatic int unsigned req_width(input int unsigned aw, input int unsigned dw);
    return aw + 1 + dw / 8 + dw;
  endfunction

endpackage

// File: rtl/mac_tcdm_req_slice_fifo.sv
// Two-entry request FIFO with synchronous flush; head is visible on data_o.
module mac_tcdm_req_slice_fifo #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             empty_next_o
);

  logic [1:0][WIDTH-1:0] mem_q, mem_d;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic [1:0]            cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) begin
      mem_d[wr_q] = data_i;
      wr_d        = ~wr_q;
    end
    if (pop_i) rd_d = ~rd_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      mem_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign data_o       = mem_q[rd_q];
  assign full_o       = (cnt_q == 2'd2);
  assign empty_o      = (cnt_q == 2'd0);
  assign empty_next_o = flush_i | (cnt_d == 2'd0);

endmodule

// File: rtl/mac_tcdm_req_slice.sv
// Elastic per-port TCDM request slice: 2-entry buffer, outstanding limiter,
// sticky protocol-error flag and a global drain for quiescing before reconfiguration.
module mac_tcdm_req_slice
  import mac_tcdm_req_slice_pkg::*;
#(
  parameter int unsigned MP              = DEF_MP,
  parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         drain_i,
  output logic                         busy_o,
  output logic [MP-1:0]                err_o,
  input  logic [MP-1:0]                in_req,
  input  logic [MP-1:0]                in_wen,
  input  logic [MP*ADDR_WIDTH-1:0]     in_add,
  input  logic [MP*(DATA_WIDTH/8)-1:0] in_be,
  input  logic [MP*DATA_WIDTH-1:0]     in_data,
  output logic [MP-1:0]                in_gnt,
  output logic [MP*DATA_WIDTH-1:0]     in_r_data,
  output logic [MP-1:0]                in_r_valid,
  output logic [MP-1:0]                tcdm_req,
  output logic [MP-1:0]                tcdm_wen,
  output logic [MP*ADDR_WIDTH-1:0]     tcdm_add,
  output logic [MP*(DATA_WIDTH/8)-1:0] tcdm_be,
  output logic [MP*DATA_WIDTH-1:0]     tcdm_data,
  input  logic [MP-1:0]                tcdm_gnt,
  input  logic [MP*DATA_WIDTH-1:0]     tcdm_r_data,
  input  logic [MP-1:0]                tcdm_r_valid
);

  localparam int unsigned BW = DATA_WIDTH / 8;
  localparam int unsigned EW = req_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  logic [MP-1:0] port_busy;
  logic          busy_q, busy_d;

  assign in_r_valid = tcdm_r_valid;
  assign in_r_data  = tcdm_r_data;

  for (genvar p = 0; p < MP; p++) begin : g_port
    logic [EW-1:0] wdata, head;
    logic          full, empty, empty_next, push, pop;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    assign wdata = {in_add[p*ADDR_WIDTH +: ADDR_WIDTH], in_wen[p],
                    in_be[p*BW +: BW], in_data[p*DATA_WIDTH +: DATA_WIDTH]};

    assign in_gnt[p]   = ~full & ~drain_i & ~rst_i;
    assign push        = in_req[p] & in_gnt[p];
    assign tcdm_req[p] = ~empty & (cnt_q < CNT_MAX);
    assign pop         = tcdm_req[p] & tcdm_gnt[p];

    mac_tcdm_req_slice_fifo #(
      .WIDTH (EW)
    ) i_fifo (
      .clk_i        (clk_i),
      .flush_i      (rst_i),
      .push_i       (push),
      .data_i       (wdata),
      .pop_i        (pop),
      .data_o       (head),
      .full_o       (full),
      .empty_o      (empty),
      .empty_next_o (empty_next)
    );

    // Payload is zeroed while nothing is buffered so idle lines never show stale data.
    assign {tcdm_add[p*ADDR_WIDTH +: ADDR_WIDTH], tcdm_wen[p],
            tcdm_be[p*BW +: BW], tcdm_data[p*DATA_WIDTH +: DATA_WIDTH]} = empty ? '0 : head;

    always_comb begin
      cnt_d = cnt_q;
      if (pop && !tcdm_r_valid[p]) begin
        cnt_d = cnt_q + CW'(1);
      end else if (!pop && tcdm_r_valid[p] && (cnt_q != '0)) begin
        cnt_d = cnt_q - CW'(1);
      end
      err_d = err_q | (tcdm_r_valid[p] & (cnt_q == '0));
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        err_q <= err_d;
      end
    end

    assign err_o[p]     = err_q;
    assign port_busy[p] = ~empty_next | (cnt_d != '0);
  end

  assign busy_d = |port_busy;

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= 1'b0;
    else       busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: tb/tb_mac_tcdm_req_slice.sv
// Directed bench for mac_tcdm_req_slice with a queue-based reference model.
module tb_mac_tcdm_req_slice;
  import mac_tcdm_req_slice_pkg::*;

  localparam int MP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int MO = 4;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             drain_i = 1'b0;
  logic             busy_o;
  logic [MP-1:0]    err_o;
  logic [MP-1:0]    in_req = '0, in_wen = '0;
  logic [MP*AW-1:0] in_add = '0;
  logic [MP*BW-1:0] in_be = '0;
  logic [MP*DW-1:0] in_data = '0;
  logic [MP-1:0]    in_gnt, in_r_valid;
  logic [MP*DW-1:0] in_r_data;
  logic [MP-1:0]    tcdm_req, tcdm_wen;
  logic [MP*AW-1:0] tcdm_add;
  logic [MP*BW-1:0] tcdm_be;
  logic [MP*DW-1:0] tcdm_data;
  logic [MP-1:0]    tcdm_gnt = '0, tcdm_r_valid = '0;
  logic [MP*DW-1:0] tcdm_r_data = '0;

  mac_tcdm_req_slice #(
    .MP (MP), .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .MAX_OUTSTANDING (MO)
  ) dut (
    .clk_i (clk), .rst_i (rst_i), .drain_i (drain_i), .busy_o (busy_o), .err_o (err_o),
    .in_req (in_req), .in_wen (in_wen), .in_add (in_add), .in_be (in_be), .in_data (in_data),
    .in_gnt (in_gnt), .in_r_data (in_r_data), .in_r_valid (in_r_valid),
    .tcdm_req (tcdm_req), .tcdm_wen (tcdm_wen), .tcdm_add (tcdm_add), .tcdm_be (tcdm_be),
    .tcdm_data (tcdm_data), .tcdm_gnt (tcdm_gnt), .tcdm_r_data (tcdm_r_data),
    .tcdm_r_valid (tcdm_r_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: per-port queue of buffered requests, outstanding count, sticky error.
  tcdm_req_t   mq [MP][$];
  int          mout [MP];
  logic [MP-1:0] merr = '0;
  logic        mbusy = 1'b0;

  initial for (int p = 0; p < MP; p++) mout[p] = 0;

  always @(negedge clk) begin
    logic [MP-1:0] eg, er;
    tcdm_req_t     e;
    for (int p = 0; p < MP; p++) begin
      eg[p] = (mq[p].size() < 2) && !drain_i && !rst_i;
      er[p] = (mq[p].size() > 0) && (mout[p] < MO);
    end
    check("in_gnt", in_gnt, eg);
    check("tcdm_req", tcdm_req, er);
    check("busy_o", busy_o, mbusy);
    check("err_o", err_o, merr);
    check("in_r_valid", in_r_valid, tcdm_r_valid);
    check("in_r_data", in_r_data, tcdm_r_data);
    for (int p = 0; p < MP; p++) begin
      if (mq[p].size() > 0) begin
        e = mq[p][0];
        check("tcdm_add", tcdm_add[p*AW +: AW], e.add);
        check("tcdm_wen", tcdm_wen[p], e.wen);
        check("tcdm_be", tcdm_be[p*BW +: BW], e.be);
        check("tcdm_data", tcdm_data[p*DW +: DW], e.data);
      end
    end
    // Advance the model to the state after the coming rising edge.
    if (rst_i) begin
      for (int p = 0; p < MP; p++) begin
        mq[p].delete();
        mout[p] = 0;
      end
      merr  = '0;
      mbusy = 1'b0;
    end else begin
      mbusy = 1'b0;
      for (int p = 0; p < MP; p++) begin
        if (er[p] && tcdm_gnt[p]) void'(mq[p].pop_front());
        if (in_req[p] && eg[p]) begin
          e.add  = in_add[p*AW +: AW];
          e.wen  = in_wen[p];
          e.be   = in_be[p*BW +: BW];
          e.data = in_data[p*DW +: DW];
          mq[p].push_back(e);
        end
        if (tcdm_r_valid[p] && mout[p] == 0) merr[p] = 1'b1;
        if (er[p] && tcdm_gnt[p] && !tcdm_r_valid[p]) mout[p]++;
        else if (!(er[p] && tcdm_gnt[p]) && tcdm_r_valid[p] && mout[p] > 0) mout[p]--;
        if (mq[p].size() > 0 || mout[p] > 0) mbusy = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic wen, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] d);
    in_req[p]          = 1'b1;
    in_wen[p]          = wen;
    in_add[p*AW +: AW] = a;
    in_be[p*BW +: BW]  = be;
    in_data[p*DW +: DW] = d;
  endtask

  task automatic drain_port(input int p);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mq[p].size() == 0 && mout[p] == 0) begin
        tcdm_r_valid[p] = 1'b0;
        return;
      end
      tcdm_gnt[p]            = 1'b1;
      tcdm_r_valid[p]        = (mout[p] > 0);
      tcdm_r_data[p*DW +: DW] = $urandom;
    end
    tcdm_r_valid[p] = 1'b0;
    check("drain_timeout", 128'(mq[p].size() + mout[p]), 0);
  endtask

  initial begin
    int acc, pops;
    repeat (2) tick();
    #1;
    check("rst_tcdm_req", tcdm_req, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    check("rst_in_gnt", in_gnt, 0);
    check("rst_tcdm_add", tcdm_add, 0);
    rst_i = 1'b0;
    #1 check("gnt_after_rst", in_gnt, 4'hF);

    // Single read on port 0, response two cycles after acceptance.
    tick();
    set_req(0, 1'b1, 32'h100, 4'hF, 32'h0);
    tcdm_gnt[0] = 1'b1;
    #1 check("t1_gnt", in_gnt[0], 1);
    tick();
    in_req[0] = 1'b0;
    #1;
    check("t1_req", tcdm_req[0], 1);
    check("t1_add", tcdm_add[31:0], 32'h100);
    check("t1_be", tcdm_be[3:0], 4'hF);
    tick();
    tcdm_r_valid[0]   = 1'b1;
    tcdm_r_data[31:0] = 32'hCAFE0001;
    #1;
    check("t1_rvalid", in_r_valid[0], 1);
    check("t1_rdata", in_r_data[31:0], 32'hCAFE0001);
    check("t1_busy_hi", busy_o, 1);
    tick();
    tcdm_r_valid[0] = 1'b0;
    #1 check("t1_busy_lo", busy_o, 0);

    // Backpressure: downstream grant low, upstream request held for 5 cycles.
    tcdm_gnt[0] = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      set_req(0, 1'b0, 32'h200 + i, 4'h3, 32'hD000 + i);
      #1 if (in_gnt[0]) acc++;
    end
    tick();
    in_req[0] = 1'b0;
    #1;
    check("t2_accepted", acc, 2);
    check("t2_full_gnt", in_gnt[0], 0);
    tcdm_gnt[0] = 1'b1;
    #1;
    check("t2_iss0_req", tcdm_req[0], 1);
    check("t2_iss0_add", tcdm_add[31:0], 32'h200);
    tick();
    #1;
    check("t2_iss1_req", tcdm_req[0], 1);
    check("t2_iss1_add", tcdm_add[31:0], 32'h201);
    check("t2_iss1_data", tcdm_data[31:0], 32'hD001);
    tick();
    #1 check("t2_done_req", tcdm_req[0], 0);
    drain_port(0);

    // Outstanding limiter on port 1.
    tcdm_gnt[1] = 1'b1;
    pops = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      set_req(1, 1'b1, 32'h300 + i, 4'hF, 32'h0);
      #1 if (tcdm_req[1] && tcdm_gnt[1]) pops++;
    end
    tick();
    in_req[1] = 1'b0;
    #1;
    check("t3_pops", pops, 4);
    check("t3_stalled", tcdm_req[1], 0);
    tcdm_r_valid[1] = 1'b1;
    tick();
    tcdm_r_valid[1] = 1'b0;
    #1;
    check("t3_reissue", tcdm_req[1], 1);
    check("t3_reissue_add", tcdm_add[63:32], 32'h304);
    drain_port(1);

    // Drain on port 3 with 3 outstanding and 2 buffered.
    tcdm_gnt[3] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      set_req(3, 1'b1, 32'h400 + i, 4'hF, 32'h0);
    end
    tick();
    in_req[3] = 1'b0;
    tick();
    tcdm_gnt[3] = 1'b0;
    set_req(3, 1'b1, 32'h403, 4'hF, 32'h0);
    tick();
    set_req(3, 1'b1, 32'h404, 4'hF, 32'h0);
    tick();
    drain_i = 1'b1;
    set_req(3, 1'b1, 32'h405, 4'hF, 32'h0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      tcdm_gnt[3]     = 1'b1;
      tcdm_r_valid[3] = 1'b1;
      tcdm_r_data[127:96] = 32'hB000 + i;
      #1;
      check("t4_drain_gnt", in_gnt[3], 0);
      check("t4_busy_hi", busy_o, 1);
    end
    tick();
    tcdm_r_valid[3] = 1'b0;
    #1;
    check("t4_busy_lo", busy_o, 0);
    check("t4_still_blocked", in_gnt[3], 0);
    in_req[3] = 1'b0;
    drain_i   = 1'b0;

    // Unsolicited response on port 2.
    tick();
    tcdm_r_valid[2] = 1'b1;
    tick();
    tcdm_r_valid[2] = 1'b0;
    #1 check("t5_err", err_o, 4'b0100);
    repeat (3) tick();
    #1 check("t5_err_held", err_o, 4'b0100);

    // Reset with full buffers everywhere and one request outstanding on port 0.
    tick();
    tcdm_gnt = 4'b0001;
    set_req(0, 1'b1, 32'h500, 4'hF, 32'h0);
    tick();
    for (int p = 0; p < MP; p++) set_req(p, 1'b0, 32'h600 + p, 4'h1, 32'hE0 + p);
    tick();
    tcdm_gnt = 4'b0000;
    tick();
    rst_i = 1'b1;
    #1 check("t6_gnt_in_rst", in_gnt, 0);
    tick();
    rst_i  = 1'b0;
    in_req = '0;
    #1;
    check("t6_req_cleared", tcdm_req, 0);
    check("t6_busy_cleared", busy_o, 0);
    check("t6_err_cleared", err_o, 0);
    check("t6_gnt_after", in_gnt, 4'hF);
    tcdm_r_valid[0] = 1'b1;
    tick();
    tcdm_r_valid[0] = 1'b0;
    #1 check("t6_late_resp_err", err_o, 4'b0001);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mac_tcdm_req_slice.md
# mac_tcdm_req_slice

Parametrised, elastic TCDM request slice between the MAC engine's flattened TCDM master ports and the cluster interconnect. It generalises the flat port binding to MP independent channels, each with a 2-entry request buffer, a per-port outstanding-response limiter and a sticky protocol-error flag. A global drain/flush handshake lets the controller quiesce all ports before reconfiguration.

## Interface
- MP, 4: number of TCDM channels
- ADDR_WIDTH, 32: address width
- DATA_WIDTH, 32: data width; byte enable is DATA_WIDTH/8
- MAX_OUTSTANDING, 4: max granted-but-unanswered requests per port (1..15)
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset, synchronous, active-high
- drain_i  in  1  level; while high no new upstream requests are accepted
- busy_o  out  1  any buffer non-empty or any outstanding count non-zero
- err_o  out  MP  sticky per-port error: r_valid received with outstanding count 0
- in_req/in_wen  in  MP  upstream request / write-enable-low (1 = read), per port
- in_add  in  MP x ADDR_WIDTH  upstream address
- in_be  in  MP x DATA_WIDTH/8  upstream byte enable
- in_data  in  MP x DATA_WIDTH  upstream write data
- in_gnt  out  MP  upstream grant
- in_r_data  out  MP x DATA_WIDTH  response data to engine
- in_r_valid  out  MP  response valid to engine
- tcdm_req/tcdm_wen  out  MP  downstream request / wen
- tcdm_add, tcdm_be, tcdm_data  out  MP x widths as upstream
- tcdm_gnt  in  MP  downstream grant
- tcdm_r_data  in  MP x DATA_WIDTH  downstream response data
- tcdm_r_valid  in  MP  downstream response valid

## Operation
- Per port, independent; no inter-port ordering.
- Push: in_req & in_gnt writes {add,wen,be,data} into the port FIFO.
- in_gnt = !full & !drain_i & !rst_i; no same-cycle pass-through when full.
- Downstream: tcdm_req = !empty & (cnt < MAX_OUTSTANDING); payload = FIFO head. Pop on tcdm_req & tcdm_gnt.
- Every granted downstream request (read or write) gets exactly one tcdm_r_valid, in order.
- cnt: +1 on pop, -1 on tcdm_r_valid; both same cycle: unchanged. Width clog2(MAX_OUTSTANDING+1).
- tcdm_r_valid with cnt == 0: cnt stays 0, err_o[p] sets, held until reset.
- Responses forwarded combinationally: in_r_valid = tcdm_r_valid, in_r_data = tcdm_r_data.
- Drain: drain_i blocks new pushes only; buffered requests still issue and responses still return. busy_o falls when all FIFOs empty and all cnt == 0.
- Reset mid-operation: FIFOs and counters cleared, buffered requests dropped; responses arriving after reset for pre-reset requests count as errors.

## Timing
- Reset values: in_gnt 0 during reset, tcdm_req 0, tcdm_add/be/data/wen 0, in_r_valid follows tcdm_r_valid, busy_o 0, err_o 0.
- Request latency: accepted at cycle t -> tcdm_req earliest t+1.
- Throughput: 1 request/cycle/port sustained when tcdm_gnt held high and cnt below limit.
- FIFO full when 2 entries; with tcdm_gnt low, 2 requests accepted then in_gnt drops in the following cycle.
- Limiter: with MAX_OUTSTANDING = N and no responses, exactly N downstream grants, then tcdm_req low until r_valid.
- tcdm_req, once high, stays high with stable payload until tcdm_gnt (head unchanged while not popped).
- busy_o registered: deasserts the cycle after the last response/pop.

## Structure
- mac_package: typedef struct tcdm_req_t {add, wen, be, data} parametrised via package constants for default widths; MAX_OUTSTANDING default constant.
- Sub-module mac_req_fifo: 2-entry FIFO (push/pop/full/empty, flush), instantiated MP times in a generate loop; counter and error flag in the top.

## Test plan
- Single read, tcdm_gnt=1, r_valid at t+2: in_gnt at t, tcdm_req at t+1 with same add/be, in_r_valid at t+2, cnt returns to 0, busy_o low at t+3.
- tcdm_gnt held 0, in_req held 1 for 5 cycles: exactly 2 grants; in_gnt 0 afterwards; release gnt -> 2 downstream issues back to back, in order.
- MAX_OUTSTANDING=4, gnt=1, no r_valid, 8 requests: 4 downstream grants then tcdm_req low; one r_valid -> one more issue next cycle.
- drain_i=1 with 2 buffered + 3 outstanding: in_gnt stays 0, all 5 complete, busy_o falls one cycle after the last r_valid.
- r_valid on port 2 with cnt 0: err_o = 4'b0100, held; other ports unaffected; cleared only by rst_i.
- rst_i asserted with full FIFOs on all ports: next cycle tcdm_req=0, busy_o=0, in_gnt=0 during reset, 1 after.
